aes3_tx_block: RTL and testbench

Parametrised S/PDIF/AES3 biphase-mark transmitter for the audio output path. It takes stereo sample pairs of 16–24 bits through a valid/ready handshake and buffers them in a 2-entry FIFO. Each serial subframe carries the sample, the per-sample validity and user bits, a 192-frame channel-status block and even parity. Unlike the previous generation, it implements channel status, V/U bits, underrun handling and block framing.

---
 rtl/aes3_tx_block.sv | 196 +++++++++++++++++++
 tb/tb_aes3_tx_block.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes3_tx_block.sv
// aes3_tx_block: S/PDIF / AES3 biphase-mark transmitter.
// 2-deep sample FIFO, V/U bits, channel-status block, even parity.
module aes3_tx_block #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CS_FRAMES    = 192
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  input  logic [1:0]              s_v,
  input  logic [1:0]              s_u,
  input  logic [CS_FRAMES-1:0]    cs_i,
  output logic                    tx_o,
  output logic                    block_start_o,
  output logic                    underrun_o
);

  localparam int FW  = (CS_FRAMES > 1) ? $clog2(CS_FRAMES) : 1;
  localparam int EW  = 2 * SAMPLE_WIDTH + 4;
  localparam int PAD = 24 - SAMPLE_WIDTH;

  localparam logic [FW-1:0] LAST = FW'(CS_FRAMES - 1);

  localparam logic [0:0] SUB_A = 1'b0;
  localparam logic [0:0] SUB_B = 1'b1;

  localparam logic [7:0] PRE_Z = 8'b11101000;
  localparam logic [7:0] PRE_X = 8'b11100010;
  localparam logic [7:0] PRE_Y = 8'b11100100;

  logic [5:0]    half_cnt;
  logic [0:0]    sub;
  logic [FW-1:0] frame_cnt;

  logic [EW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nx;
  logic          push;
  logic          pop;
  logic          frame_start;

  logic [EW-1:0]           rd_e;
  logic [SAMPLE_WIDTH-1:0] rd_l;
  logic [SAMPLE_WIDTH-1:0] rd_r;
  logic [23:0]             l24;
  logic [23:0]             r24;

  logic [23:0] cur_l;
  logic [23:0] cur_r;
  logic [1:0]  cur_v;
  logic [1:0]  cur_u;

  logic [CS_FRAMES-1:0] cs_sh;

  logic        pre_inv;
  logic        parity;
  logic [31:0] dw;
  logic        dbit;
  logic [7:0]  pre_pat;
  logic        pre_lvl;
  logic        pre_bit;
  logic        is_pre;
  logic        is_even;
  logic        is_odd;
  logic        tx_nx;

  assign frame_start = ce && half_cnt == 6'd0 && sub == SUB_A;
  assign push        = s_valid && s_ready;
  assign pop         = frame_start && count != 2'd0;

  always_comb begin
    count_nx = count + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_left, s_right, s_v, s_u};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      s_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count   <= count_nx;
      s_ready <= count_nx != 2'd2;
    end
  end

  assign rd_e = mem[rd_ptr];
  assign rd_l = rd_e[EW-1 -: SAMPLE_WIDTH];
  assign rd_r = rd_e[4 +: SAMPLE_WIDTH];
  assign l24  = 24'(rd_l) << PAD;
  assign r24  = 24'(rd_r) << PAD;

  // An empty FIFO at frame start sends silence flagged invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_l <= '0;
      cur_r <= '0;
      cur_v <= 2'b00;
      cur_u <= 2'b00;
      cs_sh <= '0;
    end else if (frame_start) begin
      if (pop) begin
        cur_l <= l24;
        cur_r <= r24;
        cur_v <= rd_e[3:2];
        cur_u <= rd_e[1:0];
      end else begin
        cur_l <= '0;
        cur_r <= '0;
        cur_v <= 2'b11;
        cur_u <= 2'b00;
      end
      if (frame_cnt == '0) cs_sh <= cs_i;
    end
  end

  always_comb begin
    dw       = '0;
    dw[27:4] = (sub == SUB_A) ? cur_l : cur_r;
    dw[28]   = cur_v[sub];
    dw[29]   = cur_u[sub];
    dw[30]   = cs_sh[frame_cnt];
  end

  assign dbit = (half_cnt[5:1] == 5'd31) ? parity : dw[half_cnt[5:1]];

  always_comb begin
    pre_pat = PRE_Y;
    if (sub == SUB_A) begin
      pre_pat = (frame_cnt == '0) ? PRE_Z : PRE_X;
    end
  end

  assign pre_lvl = (half_cnt == 6'd0) ? tx_o : pre_inv;
  assign pre_bit = pre_pat[3'd7 - half_cnt[2:0]] ^ pre_lvl;

  assign is_pre  = half_cnt < 6'd8;
  assign is_even = !is_pre && !half_cnt[0];
  assign is_odd  = !is_pre && half_cnt[0];

  always_comb begin
    tx_nx = tx_o;
    unique case (1'b1)
      is_pre:  tx_nx = pre_bit;
      is_even: tx_nx = ~tx_o;
      is_odd:  tx_nx = tx_o ^ dbit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_cnt      <= 6'd0;
      sub           <= SUB_A;
      frame_cnt     <= '0;
      tx_o          <= 1'b0;
      pre_inv       <= 1'b0;
      parity        <= 1'b0;
      block_start_o <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      block_start_o <= frame_start && frame_cnt == '0;
      underrun_o    <= frame_start && count == 2'd0;
      if (ce) begin
        tx_o     <= tx_nx;
        half_cnt <= half_cnt + 6'd1;
        if (half_cnt == 6'd0) begin
          pre_inv <= tx_o;
          parity  <= 1'b0;
        end else if (is_odd && half_cnt <= 6'd61) begin
          parity <= parity ^ dbit;
        end
        if (half_cnt == 6'd63) begin
          sub <= ~sub;
          if (sub == SUB_B) begin
            frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aes3_tx_block.sv
// tb_aes3_tx_block: random stimulus vs subframe-level waveform model
// for a 24-bit/192-frame and a 16-bit/4-frame transmitter.
module tb_aes3_tx_block;

  localparam int CSF [2] = '{192, 4};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b0;
  logic         s_valid = 1'b0;
  logic [23:0]  s_left = '0;
  logic [23:0]  s_right = '0;
  logic [1:0]   s_v = '0;
  logic [1:0]   s_u = '0;
  logic [191:0] cs = '0;

  logic rdy0, tx0, bs0, ur0;
  logic rdy1, tx1, bs1, ur1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  aes3_tx_block #(.SAMPLE_WIDTH(24), .CS_FRAMES(192)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .s_valid(s_valid), .s_ready(rdy0),
    .s_left(s_left), .s_right(s_right),
    .s_v(s_v), .s_u(s_u), .cs_i(cs),
    .tx_o(tx0), .block_start_o(bs0), .underrun_o(ur0)
  );

  aes3_tx_block #(.SAMPLE_WIDTH(16), .CS_FRAMES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .s_valid(s_valid), .s_ready(rdy1),
    .s_left(s_left[23:8]), .s_right(s_right[23:8]),
    .s_v(s_v), .s_u(s_u), .cs_i(cs[3:0]),
    .tx_o(tx1), .block_start_o(bs1), .underrun_o(ur1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state, one set per instance
  int           m_half [2];
  int           m_sub [2];
  int           m_frame [2];
  logic         m_lvl [2];
  logic         m_rdy [2];
  logic         m_bs [2];
  logic         m_ur [2];
  logic [191:0] m_cs [2];
  logic [23:0]  q_l [2][2];
  logic [23:0]  q_r [2][2];
  logic [1:0]   q_v [2][2];
  logic [1:0]   q_u [2][2];
  int           q_n [2];
  logic [23:0]  c_l [2];
  logic [23:0]  c_r [2];
  logic [1:0]   c_v [2];
  logic [1:0]   c_u [2];
  logic [63:0]  wave [2];
  bit           chk_en = 1'b0;

  task automatic build_wave(input int k);
    logic [31:0] b;
    logic [23:0] a;
    logic [7:0]  pat;
    logic        l;
    int          ones;
    b = '0;
    a = (m_sub[k] == 0) ? c_l[k] : c_r[k];
    for (int s = 4; s < 28; s++) b[s] = a[s-4];
    b[28] = c_v[k][m_sub[k]];
    b[29] = c_u[k][m_sub[k]];
    b[30] = m_cs[k][m_frame[k]];
    ones = 0;
    for (int s = 4; s < 31; s++) ones += int'(b[s]);
    b[31] = (ones % 2) != 0;
    if (m_sub[k] == 1) pat = 8'b11100100;
    else if (m_frame[k] == 0) pat = 8'b11101000;
    else pat = 8'b11100010;
    if (m_lvl[k]) pat = ~pat;
    for (int h = 0; h < 8; h++) wave[k][h] = pat[7-h];
    l = pat[0];
    for (int s = 4; s < 32; s++) begin
      l = ~l;
      wave[k][2*s] = l;
      l = l ^ b[s];
      wave[k][2*s+1] = l;
    end
  endtask

  task automatic model_step();
    bit acc;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_half[k] = 0; m_sub[k] = 0; m_frame[k] = 0;
        m_lvl[k] = 1'b0; m_rdy[k] = 1'b1;
        m_bs[k] = 1'b0; m_ur[k] = 1'b0;
        m_cs[k] = '0; q_n[k] = 0;
        chk_en = 1'b1;
      end else begin
        acc = s_valid && m_rdy[k];
        m_bs[k] = 1'b0;
        m_ur[k] = 1'b0;
        if (ce) begin
          if (m_half[k] == 0) begin
            if (m_sub[k] == 0) begin
              if (m_frame[k] == 0) begin
                m_cs[k] = (k == 0) ? cs : {188'b0, cs[3:0]};
                m_bs[k] = 1'b1;
              end
              if (q_n[k] > 0) begin
                c_l[k] = q_l[k][0]; c_r[k] = q_r[k][0];
                c_v[k] = q_v[k][0]; c_u[k] = q_u[k][0];
                q_l[k][0] = q_l[k][1]; q_r[k][0] = q_r[k][1];
                q_v[k][0] = q_v[k][1]; q_u[k][0] = q_u[k][1];
                q_n[k]--;
              end else begin
                c_l[k] = '0; c_r[k] = '0;
                c_v[k] = 2'b11; c_u[k] = 2'b00;
                m_ur[k] = 1'b1;
              end
            end
            build_wave(k);
          end
          m_lvl[k] = wave[k][m_half[k]];
          m_half[k]++;
          if (m_half[k] == 64) begin
            m_half[k] = 0;
            if (m_sub[k] == 1) begin
              m_sub[k] = 0;
              m_frame[k] = (m_frame[k] + 1) % CSF[k];
            end else begin
              m_sub[k] = 1;
            end
          end
        end
        if (acc) begin
          q_l[k][q_n[k]] = (k == 0) ? s_left : {s_left[23:8], 8'h00};
          q_r[k][q_n[k]] = (k == 0) ? s_right : {s_right[23:8], 8'h00};
          q_v[k][q_n[k]] = s_v;
          q_u[k][q_n[k]] = s_u;
          q_n[k]++;
        end
        m_rdy[k] = q_n[k] < 2;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("tx24", tx0, m_lvl[0]);
      check("rdy24", rdy0, m_rdy[0]);
      check("bs24", bs0, m_bs[0]);
      check("ur24", ur0, m_ur[0]);
      check("tx16", tx1, m_lvl[1]);
      check("rdy16", rdy1, m_rdy[1]);
      check("bs16", bs1, m_bs[1]);
      check("ur16", ur1, m_ur[1]);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", tx0, 0);
    check("rst_rdy", rdy0, 1);
    check("rst_bs", bs0, 0);
    check("rst_ur", ur0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    int thr;
    bit found;

    // underrun straight after reset
    repeat (2) @(negedge clk);
    do_reset();
    ce = 1'b1;
    @(negedge clk);
    check("ur_first", ur0, 1);
    check("bs_first", bs0, 1);
    pat = {7'b0, tx0};
    repeat (7) begin
      @(negedge clk);
      pat = {pat[6:0], tx0};
    end
    check("z_pat", pat, 8'hE8);
    repeat (300) @(negedge clk);

    // single known sample
    s_left = 24'h000001; s_right = 24'h800000;
    s_v = 2'b00; s_u = 2'b00; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (500) @(negedge clk);

    // channel status block with random traffic and ce gaps
    do_reset();
    cs = '0; cs[0] = 1'b1; cs[191] = 1'b1; cs[2] = 1'b1;
    thr = 2;
    for (int i = 0; i < 52000; i++) begin
      if (i % 4096 == 0) thr = $urandom_range(0, 3);
      if (i == 12000) begin
        cs = '0; cs[5] = 1'b1; cs[191] = 1'b1; cs[1] = 1'b1;
      end
      ce = $urandom_range(0, 7) != 0;
      s_valid = $urandom_range(0, 63) < thr;
      s_left = 24'($urandom);
      s_right = 24'($urandom);
      s_v = 2'($urandom);
      s_u = 2'($urandom);
      @(negedge clk);
    end

    // backpressure with ce held low, then 1-of-4 ce
    ce = 1'b0;
    s_valid = 1'b0;
    do_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_left = 24'($urandom); s_right = 24'($urandom);
      s_v = 2'($urandom); s_u = 2'($urandom);
      @(negedge clk);
    end
    check("bp_rdy", rdy0, 0);
    repeat (4) @(negedge clk);
    check("bp_hold", rdy0, 0);
    for (int i = 0; i < 2200; i++) begin
      ce = (i % 4) == 0;
      if (rdy0) s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;

    // reset in the middle of a subframe
    ce = 1'b1;
    repeat (200) @(negedge clk);
    s_valid = 1'b1;
    s_left = 24'h5A5A5A; s_right = 24'hA5A5A5;
    @(negedge clk);
    s_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_half[0] == 37) found = 1'b1;
      else @(negedge clk);
    end
    check("wait37", found, 1);
    ce = 1'b0;
    do_reset();
    ce = 1'b1;
    @(negedge clk);
    check("flush_ur", ur0, 1);
    check("flush_bs", bs0, 1);
    repeat (400) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
